queue_axi_w_drain: RTL and testbench

QUEUE_AXI_W_DRAIN -- requirements
Module: queue_axi_w_drain

---
 rtl/queue_axi_w_drain.sv | 125 ++++++++++++
 tb/tb_queue_axi_w_drain.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_axi_w_drain.sv
// queue_axi_w_drain: drains an upstream FIFO into one AXI4 write burst per command
//   cmd_*           : burst command (start address, AWLEN-encoded length)
//   fifo_*          : FWFT FIFO head word, empty flag and pop strobe
//   aw*/w*/b*       : AXI4 write address, write data and write response channels
//   done/resp       : completion pulse and the captured write response
module queue_axi_w_drain #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic                    fifo_empty,
    input  logic [DATA_WIDTH-1:0]   fifo_head_data,
    output logic                    fifo_dequeue,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    done,
    output logic [1:0]              resp
);
    localparam logic [2:0] AW_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [1:0]              resp_q, resp_d;

    assign awaddr       = addr_q;
    assign awlen        = len_q;
    assign awsize       = AW_SIZE;
    assign awburst      = 2'b01;
    assign wdata        = fifo_head_data;
    assign wstrb        = '1;
    assign fifo_dequeue = wvalid & wready;
    assign resp         = rst ? 2'b00 : resp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                // an empty FIFO simply withholds the beat; the counter holds
                wvalid = !fifo_empty;
                wlast  = !fifo_empty && cnt_q == len_q;
                if (wvalid && wready) cnt_d = cnt_q + 8'd1;
                if (wlast && wready) state_d = RESP;
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    resp_d  = bresp;
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        // reset silences every handshake at once so a burst is abandoned without a pop
        if (rst) begin
            cmd_ready = 1'b0;
            awvalid   = 1'b0;
            wvalid    = 1'b0;
            wlast     = 1'b0;
            bready    = 1'b0;
            done      = 1'b0;
        end
    end
endmodule

// File: tb/tb_queue_axi_w_drain.sv
// tb_queue_axi_w_drain: randomized bench with a transaction-level reference model
module tb_queue_axi_w_drain;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head_data;
    logic          fifo_dequeue;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wlast;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          done;
    logic [1:0]    resp;

    queue_axi_w_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .fifo_empty(fifo_empty), .fifo_head_data(fifo_head_data), .fifo_dequeue(fifo_dequeue),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .done(done), .resp(resp)
    );

    int errors = 0;
    int checks = 0;

    // stimulus-side state
    logic [DW-1:0] words[$];
    logic [DW-1:0] src[$];
    logic [DW-1:0] fq[$];
    int gap = 0;
    bit gap_en = 0;
    int aw_p = 100, w_p = 100, b_p = 100;
    bit b_rand = 0;

    // model: 0 idle, 1 address phase, 2 data phase, 3 response phase
    int ph = 0;
    logic [AW-1:0] m_addr;
    logic [7:0] m_len;
    int m_beats = 0;
    logic [1:0] m_resp = 2'b00;
    bit pop_req = 0;
    int rd_idx = 0;
    int tot_beats = 0, dones = 0, cmds = 0;
    int b_beats = 0, b_wlast = 0, b_stall_w = 0, b_stall_aw = 0, b_empty = 0;
    logic [AW-1:0] l_awaddr;
    logic [7:0] l_awlen;
    logic [DW-1:0] first_w;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic monitor();
        bit ev;
        if (rst) begin
            chk("rst_awvalid", awvalid, 0);
            chk("rst_wvalid", wvalid, 0);
            chk("rst_wlast", wlast, 0);
            chk("rst_bready", bready, 0);
            chk("rst_dequeue", fifo_dequeue, 0);
            chk("rst_done", done, 0);
            chk("rst_resp", resp, 0);
            ph = 0;
            m_resp = 2'b00;
            pop_req = 0;
            return;
        end
        chk("cmd_ready", cmd_ready, ph == 0);
        chk("awvalid", awvalid, ph == 1);
        if (ph == 1) begin
            chk("awaddr", awaddr, m_addr);
            chk("awlen", awlen, m_len);
            chk("awsize", awsize, $clog2(DW / 8));
            chk("awburst", awburst, 2'b01);
        end
        ev = ph == 2 && !fifo_empty;
        chk("wvalid", wvalid, ev);
        chk("fifo_dequeue", fifo_dequeue, ev && wready);
        if (ev) begin
            chk("wdata", wdata, words[rd_idx]);
            chk("wlast", wlast, m_beats == int'(m_len));
            chk("wstrb", wstrb, {(DW/8){1'b1}});
        end else chk("wlast_idle", wlast, 0);
        chk("bready", bready, ph == 3);
        chk("done", done, ph == 3 && bvalid);
        chk("resp", resp, m_resp);
        pop_req = 0;
        case (ph)
            0: if (cmd_valid) begin
                m_addr = cmd_addr;
                m_len = cmd_len;
                ph = 1;
                cmds++;
                b_beats = 0; b_wlast = 0; b_stall_w = 0; b_stall_aw = 0; b_empty = 0;
            end
            1: if (awready) begin
                ph = 2;
                m_beats = 0;
                l_awaddr = awaddr;
                l_awlen = awlen;
            end else b_stall_aw++;
            2: if (fifo_empty) b_empty++;
               else if (wready) begin
                if (m_beats == 0) first_w = wdata;
                if (wlast) b_wlast++;
                rd_idx++; m_beats++; b_beats++; tot_beats++;
                pop_req = 1;
                if (m_beats > int'(m_len)) ph = 3;
               end else b_stall_w++;
            default: if (bvalid) begin
                m_resp = bresp;
                ph = 0;
                dones++;
            end
        endcase
    endtask

    // one clock cycle: settle bench-driven inputs, check the cycle, cross the edge
    task automatic tick();
        if (pop_req) void'(fq.pop_front());
        if (gap > 0) gap--;
        else if (src.size() > 0) begin
            if (gap_en && $urandom_range(0, 7) == 0) gap = $urandom_range(1, 4);
            else fq.push_back(src.pop_front());
        end
        fifo_empty = fq.size() == 0;
        fifo_head_data = fq.size() > 0 ? fq[0] : DW'($urandom);
        awready = $urandom_range(0, 99) < aw_p;
        wready = $urandom_range(0, 99) < w_p;
        bvalid = ph == 3 && $urandom_range(0, 99) < b_p;
        bresp = b_rand ? 2'($urandom_range(0, 3)) : 2'b00;
        #1;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        words.push_back(w);
        src.push_back(w);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [7:0] l);
        int c0 = cmds;
        int n = 0;
        cmd_valid = 1; cmd_addr = a; cmd_len = l;
        while (cmds == c0 && n < 500) begin tick(); n++; end
        cmd_valid = 0;
        if (cmds == c0) chk("cmd_timeout", 0, 1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (dones < target && n < 3000) begin tick(); n++; end
        if (dones < target) chk("done_timeout", dones, target);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (tot_beats < target && n < 1000) begin tick(); n++; end
        if (tot_beats < target) chk("beat_timeout", tot_beats, target);
    endtask

    initial begin
        int s;
        int l;
        rst = 1; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
        fifo_empty = 1; fifo_head_data = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        repeat (3) tick();
        rst = 0;
        tick();

        // single beat
        push(32'hA5A5_A5A5);
        repeat (2) tick();
        send(32'h1000, 8'd0);
        wait_done(1);
        tick();
        chk("sb_awaddr", l_awaddr, 32'h1000);
        chk("sb_awlen", l_awlen, 0);
        chk("sb_data", first_w, 32'hA5A5_A5A5);
        chk("sb_pops", b_beats, 1);
        chk("sb_wlast", b_wlast, 1);
        chk("sb_resp", resp, 2'b00);

        // four beats, wready low on beat 2 for three cycles
        for (int i = 0; i < 4; i++) push($urandom);
        repeat (5) tick();
        s = tot_beats;
        send(32'h2000, 8'd3);
        wait_beats(s + 1);
        w_p = 0;
        repeat (3) tick();
        w_p = 100;
        wait_done(2);
        chk("st_stall", b_stall_w, 3);
        chk("st_pops", b_beats, 4);
        chk("st_wlast", b_wlast, 1);

        // FIFO runs dry after beat 1 and refills five cycles later
        push($urandom);
        repeat (2) tick();
        s = tot_beats;
        send(32'h3000, 8'd3);
        wait_beats(s + 1);
        gap = 5;
        for (int i = 0; i < 3; i++) push($urandom);
        wait_done(3);
        chk("gap_empty", b_empty, 5);
        chk("gap_beats", b_beats, 4);

        // awready held off for six cycles
        push($urandom);
        repeat (2) tick();
        aw_p = 0;
        send(32'h4000, 8'd0);
        repeat (6) tick();
        aw_p = 100;
        wait_done(4);
        chk("aw_stall", b_stall_aw, 6);
        chk("aw_addr", l_awaddr, 32'h4000);

        // maximal burst with continuous data
        for (int i = 0; i < 256; i++) push($urandom);
        repeat (3) tick();
        send(32'h5000, 8'd255);
        wait_done(5);
        chk("max_beats", b_beats, 256);
        chk("max_wlast", b_wlast, 1);
        chk("max_empty", b_empty, 0);

        // reset after beat 2 of 4, then a clean two-beat burst drains the rest
        for (int i = 0; i < 4; i++) push($urandom);
        repeat (5) tick();
        s = tot_beats;
        send(32'h6000, 8'd3);
        wait_beats(s + 2);
        rst = 1;
        tick();
        rst = 0;
        chk("rs_pops", b_beats, 2);
        chk("rs_left", fq.size(), 2);
        tick();
        s = dones;
        send(32'h7000, 8'd1);
        wait_done(s + 1);
        chk("rs_beats", b_beats, 2);
        chk("rs_wlast", b_wlast, 1);

        // randomized bursts with backpressure, FIFO gaps and random responses
        gap_en = 1; aw_p = 60; w_p = 60; b_p = 50; b_rand = 1;
        for (int k = 0; k < 25; k++) begin
            l = $urandom_range(0, 3) == 0 ? $urandom_range(16, 40) : $urandom_range(0, 7);
            for (int i = 0; i <= l; i++) push($urandom);
            s = dones;
            send(AW'($urandom), 8'(l));
            wait_done(s + 1);
            chk("rnd_beats", b_beats, l + 1);
            chk("rnd_wlast", b_wlast, 1);
        end
        tick();
        chk("all_consumed", rd_idx, words.size());
        chk("fifo_drained", fq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
